// File: rtl/regfile_dbg.sv
// rtl/regfile_dbg.sv - debug dump/load controller for the 32 x 32-bit register file
// Halts the CPU, then streams a wrapping address range out of or into the register file.
module regfile_dbg (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        Start,
  input  logic        Mode,
  input  logic [4:0]  First,
  input  logic [4:0]  Last,
  output logic        HaltReq,
  input  logic        HaltAck,
  output logic [4:0]  Ra,
  input  logic [31:0] Qa,
  output logic [4:0]  Wr,
  output logic [31:0] D,
  output logic        We,
  output logic [31:0] OutData,
  output logic [4:0]  OutAddr,
  output logic        OutValid,
  input  logic        OutReady,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_DUMP, S_LOAD, S_FINISH} state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [5:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] d_q, d_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_addr_q, out_addr_d;
  logic        out_valid_q, out_valid_d;

  logic [4:0]  span;
  logic        issue;
  logic        accept;
  logic        in_hs;

  // Address difference wraps naturally in 5 bits, giving the 31->0 wrap for free.
  assign span   = Last - First;
  assign issue  = (state_q == S_DUMP) && (count_q != 6'd0) && (!out_valid_q || OutReady);
  assign accept = out_valid_q && OutReady;
  assign in_hs  = (state_q == S_LOAD) && (count_q != 6'd0) && InValid;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    we_d        = 1'b0;
    wr_d        = wr_q;
    d_d         = d_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          ptr_d   = First;
          count_d = {1'b0, span} + 6'd1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (HaltAck) state_d = mode_q ? S_LOAD : S_DUMP;
      end
      S_DUMP: begin
        if (issue) begin
          out_data_d  = Qa;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          ptr_d       = ptr_q + 5'd1;
          count_d     = count_q - 6'd1;
        end else if (accept) begin
          out_valid_d = 1'b0;
        end
        if (accept && (count_q == 6'd0)) state_d = S_FINISH;
      end
      S_LOAD: begin
        if (in_hs) begin
          // r0 is architecturally constant: consume the word but suppress the write.
          we_d    = (ptr_q != 5'd0);
          wr_d    = ptr_q;
          d_d     = InData;
          ptr_d   = ptr_q + 5'd1;
          count_d = count_q - 6'd1;
        end
        if (count_q == 6'd0) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      ptr_q       <= 5'd0;
      count_q     <= 6'd0;
      we_q        <= 1'b0;
      wr_q        <= 5'd0;
      d_q         <= 32'd0;
      out_data_q  <= 32'd0;
      out_addr_q  <= 5'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      we_q        <= we_d;
      wr_q        <= wr_d;
      d_q         <= d_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Status outputs decode straight from the state flop so reset clears them asynchronously.
  assign HaltReq  = (state_q == S_HALT) || (state_q == S_DUMP) || (state_q == S_LOAD);
  assign Busy     = (state_q != S_IDLE);
  assign Done     = (state_q == S_FINISH);
  assign Ra       = (state_q == S_DUMP) ? ptr_q : 5'd0;
  assign InReady  = (state_q == S_LOAD) && (count_q != 6'd0);
  assign We       = we_q;
  assign Wr       = wr_q;
  assign D        = d_q;
  assign OutData  = out_data_q;
  assign OutAddr  = out_addr_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_regfile_dbg.sv
// tb/tb_regfile_dbg.sv - directed self-checking bench for regfile_dbg
// Models the register file and CPU halt handshake around the controller.
module tb_regfile_dbg;

  logic        Clk, Clrn, Start, Mode, HaltAck, OutReady, InValid;
  logic [4:0]  First, Last;
  logic        HaltReq, We, OutValid, InReady, Busy, Done;
  logic [4:0]  Ra, Wr, OutAddr;
  logic [31:0] Qa, D, OutData, InData;

  logic [31:0] mem [32];
  logic        preload;

  int checks, errors;

  logic [4:0]  got_addr [64];
  logic [31:0] got_data [64];
  int          got_cyc  [64];
  int          got_n, done_n, stall_bad;
  bit          timed_out;

  logic [31:0] load_vals [8];
  int          load_n;
  logic [4:0]  we_addr [8];
  logic [31:0] we_data [8];
  int          we_cyc  [8];
  int          we_n;

  regfile_dbg dut (
    .Clk(Clk), .Clrn(Clrn), .Start(Start), .Mode(Mode), .First(First), .Last(Last),
    .HaltReq(HaltReq), .HaltAck(HaltAck), .Ra(Ra), .Qa(Qa), .Wr(Wr), .D(D), .We(We),
    .OutData(OutData), .OutAddr(OutAddr), .OutValid(OutValid), .OutReady(OutReady),
    .InData(InData), .InValid(InValid), .InReady(InReady), .Busy(Busy), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Qa = mem[Ra];

  always @(posedge Clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h01010101 * 32'(i);
    end else if (We) begin
      mem[Wr] = D;
    end
  end

  task automatic start_cmd(input logic m, input logic [4:0] f, input logic [4:0] l);
    @(negedge Clk);
    Start = 1'b1; Mode = m; First = f; Last = l;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic run_dump(input int budget, input bit toggle);
    logic [31:0] hd;
    logic [4:0]  ha;
    bit          held;
    got_n = 0; done_n = 0; stall_bad = 0; held = 0; timed_out = 1;
    hd = '0; ha = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      if (toggle) OutReady = ~OutReady;
      #1;
      if (held && (!OutValid || OutData !== hd || OutAddr !== ha)) stall_bad++;
      held = OutValid && !OutReady;
      hd = OutData; ha = OutAddr;
      if (OutValid && OutReady && got_n < 64) begin
        got_addr[got_n] = OutAddr; got_data[got_n] = OutData; got_cyc[got_n] = c;
        got_n++;
      end
      if (Done) begin done_n++; timed_out = 0; break; end
    end
  endtask

  task automatic run_load(input int budget, input int inject_at);
    int idx;
    idx = 0; we_n = 0; done_n = 0; timed_out = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge Clk);
      InValid = (idx < load_n);
      InData  = (idx < load_n) ? load_vals[idx] : 32'h0;
      Start   = (c == inject_at);
      if (c == inject_at) begin Mode = 1'b0; First = 5'd5; Last = 5'd7; end
      #1;
      if (We && we_n < 8) begin
        we_addr[we_n] = Wr; we_data[we_n] = D; we_cyc[we_n] = c;
        we_n++;
      end
      if (InValid && InReady) idx++;
      if (Done) begin done_n++; timed_out = 0; break; end
    end
    InValid = 1'b0;
    Start = 1'b0;
  endtask

  task automatic test_reset;
    Clrn = 1'b0; Start = 0; Mode = 0; First = 0; Last = 0; HaltAck = 0;
    OutReady = 0; InValid = 0; InData = 0; preload = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    preload = 1'b0;
    #1;
    checks++; if (HaltReq !== 1'b0) begin errors++; $display("FAIL reset_haltreq got=%b exp=0", HaltReq); end
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got=%b%b exp=00", Busy, Done); end
    checks++; if (We !== 1'b0 || OutValid !== 1'b0 || InReady !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b%b%b exp=000", We, OutValid, InReady); end
    checks++; if (Ra !== 5'd0 || Wr !== 5'd0 || OutAddr !== 5'd0) begin errors++; $display("FAIL reset_addrs got=%0d/%0d/%0d exp=0/0/0", Ra, Wr, OutAddr); end
    checks++; if (D !== 32'd0 || OutData !== 32'd0) begin errors++; $display("FAIL reset_data got=%h/%h exp=0/0", D, OutData); end
    Clrn = 1'b1;
    HaltAck = 1'b1;
  endtask

  task automatic test_full_dump;
    logic [31:0] exp_d;
    OutReady = 1'b1;
    start_cmd(1'b0, 5'd0, 5'd31);
    run_dump(100, 1'b0);
    checks++; if (timed_out || done_n !== 1) begin errors++; $display("FAIL full_done got=%0d exp=1", done_n); end
    checks++; if (got_n !== 32) begin errors++; $display("FAIL full_count got=%0d exp=32", got_n); end
    for (int i = 0; i < 32 && i < got_n; i++) begin
      exp_d = 32'h01010101 * 32'(i);
      checks++;
      if (got_addr[i] !== 5'(i) || got_data[i] !== exp_d) begin
        errors++; $display("FAIL full_word%0d got=%0d:%h exp=%0d:%h", i, got_addr[i], got_data[i], i, exp_d);
      end
    end
    if (got_n == 32) begin
      checks++; if (got_cyc[31] - got_cyc[0] !== 31) begin errors++; $display("FAIL full_rate got=%0d exp=31", got_cyc[31] - got_cyc[0]); end
    end
    checks++; if (HaltReq !== 1'b0) begin errors++; $display("FAIL full_haltreq_at_done got=%b exp=0", HaltReq); end
    @(negedge Clk); #1;
    checks++; if (Done !== 1'b0 || Busy !== 1'b0 || HaltReq !== 1'b0) begin errors++; $display("FAIL full_after got=%b%b%b exp=000", Done, Busy, HaltReq); end
  endtask

  task automatic test_wrap_backpressure;
    logic [4:0]  ea;
    OutReady = 1'b1;
    start_cmd(1'b0, 5'd30, 5'd1);
    run_dump(100, 1'b1);
    checks++; if (timed_out || done_n !== 1) begin errors++; $display("FAIL wrap_done got=%0d exp=1", done_n); end
    checks++; if (got_n !== 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", got_n); end
    for (int i = 0; i < 4 && i < got_n; i++) begin
      ea = 5'(30 + i);
      checks++;
      if (got_addr[i] !== ea || got_data[i] !== 32'h01010101 * 32'(ea)) begin
        errors++; $display("FAIL wrap_word%0d got=%0d:%h exp=%0d:%h", i, got_addr[i], got_data[i], ea, 32'h01010101 * 32'(ea));
      end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL wrap_stall_stable got=%0d exp=0", stall_bad); end
    OutReady = 1'b1;
  endtask

  task automatic test_halt_handshake;
    @(negedge Clk);
    HaltAck = 1'b0;
    OutReady = 1'b1;
    start_cmd(1'b0, 5'd3, 5'd4);
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk); #1;
      checks++;
      if (HaltReq !== 1'b1 || Busy !== 1'b1 || Ra !== 5'd0 || OutValid !== 1'b0 || InReady !== 1'b0) begin
        errors++; $display("FAIL halt_wait%0d got=%b%b/%0d/%b%b exp=11/0/00", c, HaltReq, Busy, Ra, OutValid, InReady);
      end
    end
    HaltAck = 1'b1;
    run_dump(50, 1'b0);
    checks++; if (timed_out || got_n !== 2) begin errors++; $display("FAIL halt_count got=%0d exp=2", got_n); end
    checks++; if (got_addr[0] !== 5'd3 || got_addr[1] !== 5'd4 || got_data[1] !== 32'h04040404) begin
      errors++; $display("FAIL halt_words got=%0d,%0d:%h exp=3,4:04040404", got_addr[0], got_addr[1], got_data[1]);
    end
  endtask

  task automatic test_reset_mid_dump;
    int seen, dn;
    OutReady = 1'b1;
    start_cmd(1'b0, 5'd0, 5'd31);
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge Clk); #1;
      if (OutValid && OutReady) seen++;
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL rst_pre_words got=%0d exp=3", seen); end
    @(posedge Clk); #2;
    Clrn = 1'b0;
    #1;
    checks++; if (HaltReq !== 1'b0 || Busy !== 1'b0 || OutValid !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL rst_async got=%b%b%b%b exp=0000", HaltReq, Busy, OutValid, Done);
    end
    checks++; if (OutData !== 32'd0 || OutAddr !== 5'd0 || Ra !== 5'd0) begin
      errors++; $display("FAIL rst_async_data got=%h/%0d/%0d exp=0/0/0", OutData, OutAddr, Ra);
    end
    repeat (2) @(negedge Clk);
    Clrn = 1'b1;
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk); #1;
      if (Done || Busy || We) dn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL rst_quiet got=%0d exp=0", dn); end
    start_cmd(1'b0, 5'd10, 5'd12);
    run_dump(50, 1'b0);
    checks++; if (timed_out || got_n !== 3) begin errors++; $display("FAIL rst_redump_count got=%0d exp=3", got_n); end
    checks++; if (got_addr[0] !== 5'd10 || got_addr[2] !== 5'd12 || got_data[2] !== 32'h0C0C0C0C) begin
      errors++; $display("FAIL rst_redump_words got=%0d,%0d:%h exp=10,12:0c0c0c0c", got_addr[0], got_addr[2], got_data[2]);
    end
  endtask

  task automatic test_load_r0;
    load_vals[0] = 32'hDEADBEEF;
    load_vals[1] = 32'h12345678;
    load_n = 2;
    start_cmd(1'b1, 5'd31, 5'd0);
    run_load(50, -1);
    checks++; if (timed_out || done_n !== 1) begin errors++; $display("FAIL load_done got=%0d exp=1", done_n); end
    checks++; if (we_n !== 1) begin errors++; $display("FAIL load_we_count got=%0d exp=1", we_n); end
    checks++; if (we_addr[0] !== 5'd31 || we_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_we_word got=%0d:%h exp=31:deadbeef", we_addr[0], we_data[0]);
    end
    checks++; if (mem[31] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_r31 got=%h exp=deadbeef", mem[31]); end
    checks++; if (mem[0] !== 32'h0) begin errors++; $display("FAIL load_r0 got=%h exp=00000000", mem[0]); end
  endtask

  task automatic test_start_while_busy;
    load_vals[0] = 32'h11111111;
    load_vals[1] = 32'h22222222;
    load_vals[2] = 32'h33333333;
    load_n = 3;
    start_cmd(1'b1, 5'd2, 5'd4);
    run_load(50, 1);
    checks++; if (timed_out || done_n !== 1) begin errors++; $display("FAIL busy_done got=%0d exp=1", done_n); end
    checks++; if (we_n !== 3) begin errors++; $display("FAIL busy_we_count got=%0d exp=3", we_n); end
    if (we_n == 3) begin
      checks++; if (we_addr[0] !== 5'd2 || we_addr[1] !== 5'd3 || we_addr[2] !== 5'd4) begin
        errors++; $display("FAIL busy_we_addrs got=%0d,%0d,%0d exp=2,3,4", we_addr[0], we_addr[1], we_addr[2]);
      end
      checks++; if (we_cyc[2] - we_cyc[0] !== 2) begin errors++; $display("FAIL busy_we_b2b got=%0d exp=2", we_cyc[2] - we_cyc[0]); end
    end
    checks++; if (mem[2] !== 32'h11111111 || mem[3] !== 32'h22222222 || mem[4] !== 32'h33333333) begin
      errors++; $display("FAIL busy_mem got=%h,%h,%h exp=11111111,22222222,33333333", mem[2], mem[3], mem[4]);
    end
    checks++; if (mem[5] !== 32'h05050505 || mem[6] !== 32'h06060606 || mem[7] !== 32'h07070707) begin
      errors++; $display("FAIL busy_untouched got=%h,%h,%h exp=05050505,06060606,07070707", mem[5], mem[6], mem[7]);
    end
    @(negedge Clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after got=%b exp=0", Busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_dump();
    test_wrap_backpressure();
    test_halt_handshake();
    test_reset_mid_dump();
    test_load_r0();
    test_start_while_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
